control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter OP_W, default 64: width of the one-hot opcode input.
REQ-002 Parameter CTRL_W, default 7: width of the control word.
REQ-003 Parameter MAX_STEPS, default 4: maximum control words per opcode; STEP_W = clog2(MAX_STEPS), IDX_W = clog2(OP_W).
REQ-004 clk  input  1  single clock, all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 op_valid  input  1  opcode offered this cycle.
REQ-007 op_onehot  input  OP_W  one-hot decoded opcode.
REQ-008 op_ready  output  1  sequencer can accept an opcode.
REQ-009 ctrl  output  CTRL_W  registered control word for the current step.
REQ-010 ctrl_valid  output  1  ctrl holds a live step.
REQ-011 done  output  1  one-cycle pulse coincident with the last step of an opcode.
REQ-012 illegal  output  1  one-cycle pulse: an accepted op_onehot had zero or more than one bit set.
REQ-013 cfg_we  input  1  control-store write strobe.
REQ-014 cfg_op  input  IDX_W  opcode index to write.
REQ-015 cfg_step  input  STEP_W  step index to write.
REQ-016 cfg_data  input  CTRL_W  control word to write.
REQ-017 cfg_last  input  STEP_W  written with each word; sets the opcode's last-step index (length - 1).
REQ-018 cfg_err  output  1  one-cycle pulse: cfg_we arrived while not IDLE and was dropped.

Function
REQ-019 FSM has two states, IDLE and RUN; op_ready = (state == IDLE).
REQ-020 Handshake: an opcode is accepted on a rising edge where op_valid && op_ready.
REQ-021 On acceptance with exactly one bit set, the set bit's index and step 0 are latched, and the FSM enters RUN.
REQ-022 On acceptance with zero or multiple bits set, illegal pulses on the next cycle, state stays IDLE, and ctrl_valid stays 0.
REQ-023 In RUN, each cycle ctrl = store[idx][step] and ctrl_valid = 1; the first word appears the cycle after acceptance (latency 1).
REQ-024 step increments by 1 per cycle; at step == last[idx], done = 1 in the same cycle and the FSM returns to IDLE on the next edge.
REQ-025 Opcode length is last[idx] + 1, range 1..MAX_STEPS; no wrap past last[idx] occurs.
REQ-026 Back-to-back: op_ready rises the cycle after done; the next opcode's first word follows after one idle cycle minimum.
REQ-027 While not in RUN, ctrl = 0, ctrl_valid = 0 and done = 0.
REQ-028 cfg_we in IDLE writes store[cfg_op][cfg_step] = cfg_data and last[cfg_op] = cfg_last at that edge.
REQ-029 cfg_we in RUN is ignored and cfg_err pulses the next cycle.
REQ-030 Simultaneous cfg_we and acceptance in IDLE: the write commits first, so the accepted opcode reads the new contents.
REQ-031 op_onehot is sampled only at acceptance; changes during RUN have no effect.

Reset
REQ-032 reset_n low forces, asynchronously: state IDLE, step 0, idx 0, ctrl 0, ctrl_valid 0, done 0, illegal 0, cfg_err 0.
REQ-033 reset_n low clears all store words and all last[] entries to 0, so every opcode is one zero-word step.
REQ-034 Reset asserted mid-RUN aborts the opcode with no done pulse; after release the block is in IDLE with op_ready = 1.

Structure
REQ-035 A shared package holds the FSM state enum, the default parameter values, and the IDX_W/STEP_W derivation functions.
REQ-036 A one-hot-to-index encoder with a legality flag is a natural sub-module, onehot_encode, parametrised by OP_W.

Verification
REQ-037 After reset, write opcode 4 step 0 = 7'b0010000 with last = 0; offer op_onehot = 1<<4 -> one cycle of ctrl = 0010000 with ctrl_valid = 1 and done = 1, then IDLE.
REQ-038 Write opcode 14 steps 0..2 = 7'h01, 7'h02, 7'h04 with last = 2; offer 1<<14 -> ctrl = 01, 02, 04 on three consecutive cycles, done only on the third, op_ready low for those three cycles.
REQ-039 Offer op_onehot = 0, then op_onehot = (1<<3)|(1<<5) -> illegal pulses once for each, ctrl_valid stays 0, FSM stays IDLE.
REQ-040 During the REQ-038 run, assert cfg_we for opcode 14 step 1 -> cfg_err pulses and a rerun still outputs 01, 02, 04.
REQ-041 Drop reset_n during step 1 of the REQ-038 run -> all outputs go 0 immediately, no done pulse; after release op_ready = 1.
REQ-042 Offer 1<<59 with no store writes after reset -> single step, ctrl = 0, done = 1.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared types, default sizes and width helpers for the control sequencer.
// No logic and no latency; everything here is compile-time only.
package control_sequencer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int OP_W_DEF      = 64;
  localparam int CTRL_W_DEF    = 7;
  localparam int MAX_STEPS_DEF = 4;

  function automatic int idx_width(input int op_w);
    return (op_w > 1) ? $clog2(op_w) : 1;
  endfunction

  function automatic int step_width(input int max_steps);
    return (max_steps > 1) ? $clog2(max_steps) : 1;
  endfunction

endpackage

// File: rtl/control_sequencer_onehot_encode.sv
// One-hot to binary index encoder with a legality flag (exactly one bit set).
// Purely combinational, zero latency; no flow control.
module onehot_encode
  import control_sequencer_pkg::*;
#(
  parameter int OP_W  = OP_W_DEF,
  parameter int IDX_W = idx_width(OP_W)
) (
  input  logic [OP_W-1:0]  onehot,
  output logic [IDX_W-1:0] idx,
  output logic             legal
);

  logic seen;
  logic multi;

  // OR-ing indices gives the right answer only when legal; callers must gate on it.
  always_comb begin
    idx   = '0;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < OP_W; i++) begin
      if (onehot[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
        idx   = idx | IDX_W'(i);
      end
    end
    legal = seen & ~multi;
  end

endmodule

// File: rtl/control_sequencer.sv
// Steps through a per-opcode list of control words; first word one cycle after acceptance.
// Accepts an opcode only in IDLE (op_ready); config writes are dropped with cfg_err while running.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int OP_W      = OP_W_DEF,
  parameter int CTRL_W    = CTRL_W_DEF,
  parameter int MAX_STEPS = MAX_STEPS_DEF,
  parameter int IDX_W     = idx_width(OP_W),
  parameter int STEP_W    = step_width(MAX_STEPS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              op_valid,
  input  logic [OP_W-1:0]   op_onehot,
  output logic              op_ready,
  output logic [CTRL_W-1:0] ctrl,
  output logic              ctrl_valid,
  output logic              done,
  output logic              illegal,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_op,
  input  logic [STEP_W-1:0] cfg_step,
  input  logic [CTRL_W-1:0] cfg_data,
  input  logic [STEP_W-1:0] cfg_last,
  output logic              cfg_err
);

  state_t            state, state_n;
  logic [IDX_W-1:0]  idx, idx_n, enc_idx;
  logic [STEP_W-1:0] step, step_n, step_inc, first_last;
  logic [CTRL_W-1:0] ctrl_n, first_word;
  logic              ctrl_valid_n, done_n, illegal_n, cfg_err_n;
  logic              enc_legal, cfg_wr, wr_hit;

  logic [CTRL_W-1:0] store  [OP_W][MAX_STEPS];
  logic [STEP_W-1:0] last_q [OP_W];

  onehot_encode #(
    .OP_W  (OP_W),
    .IDX_W (IDX_W)
  ) u_enc (
    .onehot (op_onehot),
    .idx    (enc_idx),
    .legal  (enc_legal)
  );

  assign op_ready = (state == IDLE);
  assign cfg_wr   = cfg_we && (state == IDLE);
  assign step_inc = step + 1'b1;

  // A write landing on the same edge as acceptance must be seen by the first step.
  assign wr_hit     = cfg_wr && (cfg_op == enc_idx);
  assign first_word = (wr_hit && (cfg_step == '0)) ? cfg_data : store[enc_idx][0];
  assign first_last = wr_hit ? cfg_last : last_q[enc_idx];

  always_comb begin
    state_n      = state;
    idx_n        = idx;
    step_n       = step;
    ctrl_n       = '0;
    ctrl_valid_n = 1'b0;
    done_n       = 1'b0;
    illegal_n    = 1'b0;
    cfg_err_n    = cfg_we && (state != IDLE);
    case (state)
      IDLE: begin
        if (op_valid) begin
          if (enc_legal) begin
            state_n      = RUN;
            idx_n        = enc_idx;
            step_n       = '0;
            ctrl_n       = first_word;
            ctrl_valid_n = 1'b1;
            done_n       = (first_last == '0);
          end else begin
            illegal_n = 1'b1;
          end
        end
      end
      RUN: begin
        if (done) begin
          state_n = IDLE;
          step_n  = '0;
        end else begin
          step_n       = step_inc;
          ctrl_n       = store[idx][step_inc];
          ctrl_valid_n = 1'b1;
          done_n       = (step_inc == last_q[idx]);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      step       <= '0;
      ctrl       <= '0;
      ctrl_valid <= 1'b0;
      done       <= 1'b0;
      illegal    <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      step       <= step_n;
      ctrl       <= ctrl_n;
      ctrl_valid <= ctrl_valid_n;
      done       <= done_n;
      illegal    <= illegal_n;
      cfg_err    <= cfg_err_n;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int o = 0; o < OP_W; o++) begin
        last_q[o] <= '0;
        for (int s = 0; s < MAX_STEPS; s++) begin
          store[o][s] <= '0;
        end
      end
    end else if (cfg_wr) begin
      store[cfg_op][cfg_step] <= cfg_data;
      last_q[cfg_op]          <= cfg_last;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized and directed bench for control_sequencer against a queue-based reference model.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        op_valid;
  logic [63:0] op_onehot;
  logic        op_ready;
  logic [6:0]  ctrl;
  logic        ctrl_valid;
  logic        done;
  logic        illegal;
  logic        cfg_we;
  logic [5:0]  cfg_op;
  logic [1:0]  cfg_step;
  logic [6:0]  cfg_data;
  logic [1:0]  cfg_last;
  logic        cfg_err;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: store contents plus the queue of words still to be emitted.
  logic [6:0] mstore [64][4];
  logic [1:0] mlast  [64];
  logic [6:0] exp_q  [$];
  logic       e_illegal;
  logic       e_cfgerr;

  control_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op_valid   (op_valid),
    .op_onehot  (op_onehot),
    .op_ready   (op_ready),
    .ctrl       (ctrl),
    .ctrl_valid (ctrl_valid),
    .done       (done),
    .illegal    (illegal),
    .cfg_we     (cfg_we),
    .cfg_op     (cfg_op),
    .cfg_step   (cfg_step),
    .cfg_data   (cfg_data),
    .cfg_last   (cfg_last),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < 64; o++) begin
      mlast[o] = 2'd0;
      for (int s = 0; s < 4; s++) mstore[o][s] = 7'd0;
    end
    exp_q.delete();
    e_illegal = 1'b0;
    e_cfgerr  = 1'b0;
  endtask

  task automatic check_outputs();
    logic [6:0] ec;
    ec = 7'd0;
    if (exp_q.size() != 0) ec = exp_q[0];
    check_eq("ctrl",       64'(ctrl),       64'(ec));
    check_eq("ctrl_valid", 64'(ctrl_valid), 64'(exp_q.size() != 0));
    check_eq("done",       64'(done),       64'(exp_q.size() == 1));
    check_eq("op_ready",   64'(op_ready),   64'(exp_q.size() == 0));
    check_eq("illegal",    64'(illegal),    64'(e_illegal));
    check_eq("cfg_err",    64'(cfg_err),    64'(e_cfgerr));
  endtask

  // Advance one clock: update the model with the inputs seen at the edge, then check.
  task automatic tick();
    logic busy;
    int   n;
    int   oi;
    @(posedge clk);
    busy = (exp_q.size() != 0);
    n    = $countones(op_onehot);
    oi   = 0;
    for (int i = 0; i < 64; i++) if (op_onehot[i]) oi = i;
    if (busy) exp_q.delete(0);
    e_cfgerr  = cfg_we && busy;
    e_illegal = op_valid && !busy && (n != 1);
    if (cfg_we && !busy) begin
      mstore[cfg_op][cfg_step] = cfg_data;
      mlast[cfg_op]            = cfg_last;
    end
    if (op_valid && !busy && n == 1)
      for (int s = 0; s <= int'(mlast[oi]); s++) exp_q.push_back(mstore[oi][s]);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic clr();
    op_valid  = 1'b0;
    op_onehot = 64'd0;
    cfg_we    = 1'b0;
    cfg_op    = 6'd0;
    cfg_step  = 2'd0;
    cfg_data  = 7'd0;
    cfg_last  = 2'd0;
  endtask

  task automatic set_cfg(input int op, input int st, input logic [6:0] d, input int lst);
    cfg_we   = 1'b1;
    cfg_op   = 6'(op);
    cfg_step = 2'(st);
    cfg_data = d;
    cfg_last = 2'(lst);
  endtask

  task automatic offer(input logic [63:0] oh);
    op_valid  = 1'b1;
    op_onehot = oh;
  endtask

  task automatic write_op14();
    set_cfg(14, 0, 7'h01, 2); tick();
    set_cfg(14, 1, 7'h02, 2); tick();
    set_cfg(14, 2, 7'h04, 2); tick();
    clr();
  endtask

  initial begin
    int a;
    int b;
    int r;
    reset_n = 1'b0;
    clr();
    model_reset();
    #3;
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Single-step opcode 4
    set_cfg(4, 0, 7'b0010000, 0); tick();
    clr(); offer(64'd1 << 4); tick();
    check_eq("r037_ctrl", 64'(ctrl), 64'h10);
    check_eq("r037_done", 64'(done), 64'd1);
    clr(); tick();
    check_eq("r037_idle", 64'(op_ready), 64'd1);

    // Three-step opcode 14
    write_op14();
    offer(64'd1 << 14); tick();
    check_eq("r038_w0", 64'(ctrl), 64'h01);
    clr(); tick();
    check_eq("r038_w1", 64'(ctrl), 64'h02);
    check_eq("r038_rdy", 64'(op_ready), 64'd0);
    tick();
    check_eq("r038_w2", 64'(ctrl), 64'h04);
    check_eq("r038_done", 64'(done), 64'd1);
    tick();

    // Illegal opcodes
    offer(64'd0); tick();
    check_eq("r039_zero", 64'(illegal), 64'd1);
    offer((64'd1 << 3) | (64'd1 << 5)); tick();
    check_eq("r039_multi", 64'(illegal), 64'd1);
    check_eq("r039_valid", 64'(ctrl_valid), 64'd0);
    clr(); tick();

    // Config write during a run is dropped
    offer(64'd1 << 14); tick();
    clr(); set_cfg(14, 1, 7'h55, 0); tick();
    check_eq("r040_err", 64'(cfg_err), 64'd1);
    clr(); tick(); tick();
    offer(64'd1 << 14); tick();
    clr(); tick();
    check_eq("r040_w1", 64'(ctrl), 64'h02);
    tick(); tick();

    // Asynchronous reset in the middle of a run
    offer(64'd1 << 14); tick();
    clr(); tick();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    check_eq("r041_done", 64'(done), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check_eq("r041_rdy", 64'(op_ready), 64'd1);

    // Unwritten opcode after reset is one zero word
    offer(64'd1 << 59); tick();
    check_eq("r042_ctrl", 64'(ctrl), 64'd0);
    check_eq("r042_done", 64'(done), 64'd1);
    clr(); tick();

    // Random traffic, opcodes biased to a small set so writes and runs interact
    for (int k = 0; k < 1500; k++) begin
      op_valid = ($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 9);
      a = (r < 5) ? $urandom_range(0, 7) : $urandom_range(0, 63);
      if (r < 8) op_onehot = 64'd1 << a;
      else if (r == 8) op_onehot = 64'd0;
      else begin
        b = (a + 1 + $urandom_range(0, 62)) % 64;
        op_onehot = (64'd1 << a) | (64'd1 << b);
      end
      cfg_we   = ($urandom_range(0, 2) == 0);
      cfg_op   = 6'($urandom_range(0, 9));
      cfg_step = 2'($urandom_range(0, 3));
      cfg_data = 7'($urandom);
      cfg_last = 2'($urandom_range(0, 3));
      tick();
    end
    clr();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
